// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit and address layout, and the port indexing
// that the router controller uses.
package noc_pkg;

    localparam int ADDR_W = 8;
    localparam int X_MSB  = 7;
    localparam int X_LSB  = 4;
    localparam int Y_MSB  = 3;
    localparam int Y_LSB  = 0;

    localparam int FLIT_W_DEFAULT = 32;

    typedef logic [FLIT_W_DEFAULT-1:0] flit_t;

    typedef enum logic [1:0] {
        PORT_N = 2'd0,
        PORT_S = 2'd1,
        PORT_E = 2'd2,
        PORT_L = 2'd3
    } port_e;

endpackage : noc_pkg

// File: rtl/wrap_ptr.sv
// Circular-buffer pointer. It wraps from DEPTH-1 back to 0 by an explicit
// compare, so DEPTH does not have to be a power of two.
module wrap_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule : wrap_ptr

// File: rtl/router_input_fifo.sv
// Per-port router input buffer. It holds flits in a circular buffer, shows the
// head flit and its destination to the controller, and flags full to upstream.
module router_input_fifo
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_LSB   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      data_i,
    input  logic                       write_en_i,
    input  logic                       pop_i,
    output logic [DATA_WIDTH-1:0]      packet_o,
    output logic [ADDR_W-1:0]          packet_addr_o,
    output logic                       packet_valid_o,
    output logic                       buffer_full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Handshake: a flit on data_i is taken on a rising edge where write_en_i is
    // high and push_eff holds. pop_i consumes the head only while packet_valid_o
    // is high. A push while full is accepted only together with a real pop.
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic                  pop_eff;
    logic                  push_eff;

    assign pop_eff  = pop_i && (count != '0);
    assign push_eff = write_en_i && ((count != FULL_CNT) || pop_eff);

    wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_eff),
        .ptr (rd_ptr)
    );

    wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_eff),
        .ptr (wr_ptr)
    );

    // Storage has no reset; the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({push_eff, pop_eff})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_o <= 1'b0;
        end else if (write_en_i && !push_eff) begin
            overflow_o <= 1'b1;
        end
    end

    assign packet_o       = mem[rd_ptr];
    assign packet_addr_o  = packet_o[ADDR_LSB +: ADDR_W];
    assign packet_valid_o = (count != '0);
    assign buffer_full_o  = (count == FULL_CNT);
    assign count_o        = count;

endmodule : router_input_fifo

// File: tb/tb_router_input_fifo.sv
// Bench for router_input_fifo with DEPTH=4: directed vectors, a reference
// occupancy model, and a queue-based scoreboard that checks popped heads.
module tb_router_input_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk;
    logic          rst;
    logic [DW-1:0] data_i;
    logic          write_en_i;
    logic          pop_i;
    logic [DW-1:0] packet_o;
    logic [7:0]    packet_addr_o;
    logic          packet_valid_o;
    logic          buffer_full_o;
    logic [CW-1:0] count_o;
    logic          overflow_o;

    logic [DW-1:0] exp_q[$];
    int            model_count;
    int            checks;
    int            errors;

    router_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_LSB(0)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_i         (data_i),
        .write_en_i     (write_en_i),
        .pop_i          (pop_i),
        .packet_o       (packet_o),
        .packet_addr_o  (packet_addr_o),
        .packet_valid_o (packet_valid_o),
        .buffer_full_o  (buffer_full_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks: one call is one clock cycle of stimulus
    task automatic step(input logic we, input logic [DW-1:0] d, input logic p);
        bit pop_e;
        bit push_e;
        write_en_i = we;
        data_i     = d;
        pop_i      = p;
        pop_e  = p && (model_count != 0);
        push_e = we && ((model_count != DEPTH) || pop_e);
        if (push_e) exp_q.push_back(d);
        model_count = model_count + int'(push_e) - int'(pop_e);
        @(posedge clk);
        #1;
        write_en_i = 1'b0;
        pop_i      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        model_count = 0;
    endtask

    // Scoreboard monitor: every accepted pop must present the oldest expected flit
    always @(negedge clk) begin
        if (!rst && pop_i && packet_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h expected no flit", packet_o);
            end else begin
                check("pop_data", packet_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        checks      = 0;
        errors      = 0;
        model_count = 0;
        rst         = 1'b1;
        data_i      = '0;
        write_en_i  = 1'b0;
        pop_i       = 1'b0;
        #2;
        check("reset_valid", 32'(packet_valid_o), 32'd0);
        check("reset_full",  32'(buffer_full_o),  32'd0);
        check("reset_count", 32'(count_o),        32'd0);
        check("reset_ovf",   32'(overflow_o),     32'd0);
        do_reset();

        // Fill to full
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'hDEAD_00A0 + 32'(i), 1'b0);
            check("fill_count", 32'(count_o), 32'(i + 1));
            check("fill_addr",  32'(packet_addr_o), 32'hA0);
            check("fill_full",  32'(buffer_full_o), (i == 3) ? 32'd1 : 32'd0);
        end

        // Push while full is dropped and overflow sticks
        step(1'b1, 32'h0000_00FF, 1'b0);
        check("drop_count", 32'(count_o), 32'd4);
        check("drop_ovf",   32'(overflow_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1);
            check("drain_ovf", 32'(overflow_o), 32'd1);
        end
        check("drain_valid", 32'(packet_valid_o), 32'd0);
        check("drain_count", 32'(count_o), 32'd0);

        // Push and pop together while full
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 32'h1111_00A0 + 32'(i), 1'b0);
        step(1'b1, 32'h2222_00B4, 1'b1);
        check("pp_full_count", 32'(count_o), 32'd4);
        check("pp_full_addr",  32'(packet_addr_o), 32'hA1);
        check("pp_full_ovf",   32'(overflow_o), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        check("pp_full_empty", 32'(packet_valid_o), 32'd0);

        // Pop while empty is ignored, the push still lands
        step(1'b1, 32'h3333_0012, 1'b1);
        check("empty_pp_valid", 32'(packet_valid_o), 32'd1);
        check("empty_pp_addr",  32'(packet_addr_o), 32'h12);
        check("empty_pp_count", 32'(count_o), 32'd1);

        // Steady push+pop with one entry resident wraps both pointers
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h4444_0020 + 32'(i), 1'b1);
            check("wrap_count", 32'(count_o), 32'd1);
            check("wrap_addr",  32'(packet_addr_o), 32'h20 + 32'(i));
        end
        step(1'b0, '0, 1'b1);
        check("wrap_empty", 32'(packet_valid_o), 32'd0);

        // Asynchronous reset between edges with three flits stored
        for (int i = 0; i < 3; i++) step(1'b1, 32'h5555_0030 + 32'(i), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(packet_valid_o), 32'd0);
        check("arst_count", 32'(count_o), 32'd0);
        check("arst_full",  32'(buffer_full_o), 32'd0);
        exp_q.delete();
        model_count = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 32'h6666_0055, 1'b0);
        step(1'b1, 32'h6666_0056, 1'b0);
        check("post_rst_addr", 32'(packet_addr_o), 32'h55);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        check("post_rst_empty", 32'(packet_valid_o), 32'd0);

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_router_input_fifo
